filter_coef_bank: RTL

- Parametrised, run-time-writable KxK convolution coefficient store.
- Replaces the fixed 3x3 file-initialised coefficient ROM and its constant address register.
- Holds an active bank, which drives the MAC array, and a shadow bank, loaded through a valid/ready stream.
- Shadow is promoted to active only at a frame boundary, so a frame never sees mixed kernels.
- Optional point-symmetric load mode halves the number of coefficients that must be streamed.

---
 rtl/filter_coef_bank_if.sv | 38 +++
 rtl/filter_coef_bank.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/filter_coef_bank_if.sv
// rtl/filter_coef_bank_if.sv - coefficient bank control/stream/status bundle
//
// Purpose: groups the load control, coefficient stream, frame sync and
// status/kernel outputs of filter_coef_bank into one interface.
// Ports (signals):
//   load_start, sym_mode       load control (master -> slave)
//   coef_in, coef_valid        coefficient stream (master -> slave)
//   coef_ready                 stream back-pressure (slave -> master)
//   frame_sync                 frame boundary pulse (master -> slave)
//   coef_flat                  active kernel, K*K*DATA_W bits (slave -> master)
//   load_done, swap_done       one-cycle status pulses (slave -> master)
//   pending, busy              status levels (slave -> master)
interface filter_coef_bank_if #(
  parameter int DATA_W = 8,
  parameter int K      = 3
) ();
  logic                    load_start;
  logic                    sym_mode;
  logic [DATA_W-1:0]       coef_in;
  logic                    coef_valid;
  logic                    coef_ready;
  logic                    frame_sync;
  logic [K*K*DATA_W-1:0]   coef_flat;
  logic                    load_done;
  logic                    swap_done;
  logic                    pending;
  logic                    busy;

  modport master (
    output load_start, sym_mode, coef_in, coef_valid, frame_sync,
    input  coef_ready, coef_flat, load_done, swap_done, pending, busy
  );

  modport slave (
    input  load_start, sym_mode, coef_in, coef_valid, frame_sync,
    output coef_ready, coef_flat, load_done, swap_done, pending, busy
  );
endinterface

// File: rtl/filter_coef_bank.sv
// rtl/filter_coef_bank.sv - run-time writable KxK coefficient bank with shadow/active swap
//
// Purpose: holds an active kernel driving coef_flat and a shadow kernel loaded
// through a valid/ready stream. The shadow is promoted to active only on
// frame_sync, so one frame never mixes two kernels. In point-symmetric mode
// only the first (K*K+1)/2 coefficients are streamed; each beat also fills its
// mirror entry K*K-1-i.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset (restores the identity kernel)
//   bus    filter_coef_bank_if.slave: load control, coefficient stream,
//          frame_sync, coef_flat and status outputs
module filter_coef_bank #(
  parameter int                DATA_W     = 8,
  parameter int                K          = 3,
  parameter logic [DATA_W-1:0] CENTER_RST = 8'h01
) (
  input  logic             clk,
  input  logic             rst_n,
  filter_coef_bank_if.slave bus
);

  localparam int NUM    = K * K;
  localparam int NSYM   = (NUM + 1) / 2;
  localparam int CENTER = (NUM - 1) / 2;
  localparam int IDX_W  = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int FW     = NUM * DATA_W;

  // Identity kernel: only the centre tap is non-zero.
  localparam logic [FW-1:0] IDENT = FW'(CENTER_RST) << (CENTER * DATA_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    last_idx;
  logic [IDX_W-1:0]    mirror_idx;
  logic                sym_q;
  logic                beat_wr;
  logic                do_swap;
  logic                load_done;
  logic                swap_done_q;
  logic [DATA_W-1:0]   shadow [NUM];
  logic [FW-1:0]       shadow_flat;
  logic [FW-1:0]       active;

  assign last_idx   = sym_q ? IDX_W'(NSYM - 1) : IDX_W'(NUM - 1);
  assign mirror_idx = IDX_W'(NUM - 1) - idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // load_start takes priority over both a beat and frame_sync in every state.
  always_comb begin
    state_nxt = state;
    beat_wr   = 1'b0;
    load_done = 1'b0;
    do_swap   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load_start) state_nxt = LOAD;
      end
      LOAD: begin
        if (bus.load_start) begin
          state_nxt = LOAD;
        end else if (bus.coef_valid) begin
          beat_wr = 1'b1;
          if (idx == last_idx) begin
            load_done = 1'b1;
            state_nxt = READY;
          end
        end
      end
      READY: begin
        if (bus.load_start) begin
          state_nxt = LOAD;
        end else if (bus.frame_sync) begin
          do_swap   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shadow_flat = '0;
    for (int j = 0; j < NUM; j++) begin
      shadow_flat[j*DATA_W +: DATA_W] = shadow[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      sym_q       <= 1'b0;
      swap_done_q <= 1'b0;
      active      <= IDENT;
      for (int j = 0; j < NUM; j++) begin
        shadow[j] <= '0;
      end
    end else begin
      swap_done_q <= do_swap;
      if (bus.load_start) begin
        idx   <= '0;
        sym_q <= bus.sym_mode;
      end else if (beat_wr && (idx != last_idx)) begin
        // Index stops at the last beat so it never wraps by overflow.
        idx <= idx + 1'b1;
      end
      // In sym mode the centre beat targets the same entry twice; harmless.
      for (int j = 0; j < NUM; j++) begin
        if (beat_wr && ((IDX_W'(j) == idx) || (sym_q && (IDX_W'(j) == mirror_idx)))) begin
          shadow[j] <= bus.coef_in;
        end
      end
      if (do_swap) begin
        active <= shadow_flat;
      end
    end
  end

  assign bus.coef_flat  = active;
  assign bus.coef_ready = (state == LOAD);
  assign bus.pending    = (state == READY);
  assign bus.busy       = (state != IDLE);
  assign bus.load_done  = load_done;
  assign bus.swap_done  = swap_done_q;

endmodule
